// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the pixel address sequencer.
//   seq_state_t : sequencer state encoding
//   MIN_DIM     : smallest image width/height that can be processed
//   is_busy     : LOAD, READ and DRAIN report the block as busy
//   is_moving   : READ and DRAIN are the states where results are accepted
// ---------------------------------------------------------------------------
package edge_pkg;

  localparam int unsigned MIN_DIM = 32'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } seq_state_t;

  function automatic logic is_busy(input seq_state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_LOAD, S_READ, S_DRAIN: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_moving(input seq_state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_READ, S_DRAIN: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Row/column position counter for a raster scan of width x height pixels.
// Ports:
//   ahb_hclk, n_rst  : clock, async active-low reset
//   clear            : synchronous clear to (0,0), wins over enable
//   enable           : advance one pixel (col first, wrap to next row)
//   width, height    : image dimensions used for the wrap points
//   row_nxt, col_nxt : position the counter will hold after this edge
//   last_pix         : current position is the last pixel of the image
// ---------------------------------------------------------------------------
module raster_counter
  import edge_pkg::*;
#(
  parameter int BUSWIDTH = 32
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [BUSWIDTH-1:0] width,
  input  logic [BUSWIDTH-1:0] height,
  output logic [BUSWIDTH-1:0] row_nxt,
  output logic [BUSWIDTH-1:0] col_nxt,
  output logic                last_pix
);

  localparam logic [BUSWIDTH-1:0] ZERO = {BUSWIDTH{1'b0}};
  localparam logic [BUSWIDTH-1:0] ONE  = {{(BUSWIDTH-1){1'b0}}, 1'b1};

  logic [BUSWIDTH-1:0] row_r;
  logic [BUSWIDTH-1:0] col_r;
  logic [BUSWIDTH-1:0] row_nxt_s;
  logic [BUSWIDTH-1:0] col_nxt_s;
  logic                last_col_s;
  logic                last_row_s;

  assign last_col_s = (col_r == (width - ONE));
  assign last_row_s = (row_r == (height - ONE));
  assign last_pix   = last_col_s & last_row_s;
  assign row_nxt    = row_nxt_s;
  assign col_nxt    = col_nxt_s;

  // Next position: clear, advance with row/image wrap, or hold
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    if (clear) begin
      row_nxt_s = ZERO;
      col_nxt_s = ZERO;
    end else if (enable) begin
      if (last_col_s) begin
        col_nxt_s = ZERO;
        row_nxt_s = last_row_s ? ZERO : (row_r + ONE);
      end else begin
        col_nxt_s = col_r + ONE;
        row_nxt_s = row_r;
      end
    end else begin
      row_nxt_s = row_r;
      col_nxt_s = col_r;
    end
  end

  // Position registers
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      row_r <= ZERO;
      col_r <= ZERO;
    end else begin
      row_r <= row_nxt_s;
      col_r <= col_nxt_s;
    end
  end

endmodule

// File: rtl/pixel_addr_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_addr_sequencer
// Generates the pixel read addresses of a source image in raster order and
// the write addresses of the (width-2)*(height-2) filtered results, started
// by a rising edge of the configuration kick-off level.
// Ports:
//   ahb_hclk, n_rst                 : clock, async active-low reset
//   start                           : kick-off level, rising edge starts a run
//   width, height                   : image size in pixels (min 3 each)
//   read_start_address              : source image base address
//   write_start_address             : result image base address
//   rd_req/rd_addr/rd_ack           : pixel read request to the bus master
//   rd_eol, rd_eof                  : current read ends a row / the image
//   res_valid/res_ready             : result handshake from the filter
//   wr_req/wr_addr/wr_ack           : result write request to the bus master
//   busy, done, err                 : status
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module pixel_addr_sequencer
  import edge_pkg::*;
#(
  parameter int BUSWIDTH = 32
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] width,
  input  logic [BUSWIDTH-1:0] height,
  input  logic [BUSWIDTH-1:0] read_start_address,
  input  logic [BUSWIDTH-1:0] write_start_address,
  output logic                rd_req,
  output logic [BUSWIDTH-1:0] rd_addr,
  input  logic                rd_ack,
  output logic                rd_eol,
  output logic                rd_eof,
  input  logic                res_valid,
  output logic                res_ready,
  output logic                wr_req,
  output logic [BUSWIDTH-1:0] wr_addr,
  input  logic                wr_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [BUSWIDTH-1:0] ZERO = {BUSWIDTH{1'b0}};
  localparam logic [BUSWIDTH-1:0] ONE  = {{(BUSWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BUSWIDTH-1:0] TWO  = {{(BUSWIDTH-2){1'b0}}, 2'b10};
  localparam logic [BUSWIDTH-1:0] MIN  = BUSWIDTH'(MIN_DIM);

  seq_state_t          state_r;
  seq_state_t          state_nxt_s;
  logic                start_q_r;

  logic [BUSWIDTH-1:0] width_r;
  logic [BUSWIDTH-1:0] height_r;
  logic [BUSWIDTH-1:0] rbase_r;
  logic [BUSWIDTH-1:0] wbase_r;
  logic [BUSWIDTH-1:0] wtotal_r;
  logic [BUSWIDTH-1:0] wcount_r;

  logic                rd_req_r;
  logic [BUSWIDTH-1:0] rd_addr_r;
  logic                rd_eol_r;
  logic                rd_eof_r;
  logic                res_ready_r;
  logic                wr_req_r;
  logic [BUSWIDTH-1:0] wr_addr_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic                edge_s;
  logic                load_s;
  logic                rd_fire_s;
  logic                wr_fire_s;
  logic                res_fire_s;
  logic                bad_dim_s;
  logic [BUSWIDTH-1:0] cfg_w_s;
  logic [BUSWIDTH-1:0] cfg_h_s;
  logic [BUSWIDTH-1:0] rbase_s;
  logic [BUSWIDTH-1:0] wtotal_s;
  logic [BUSWIDTH-1:0] wcount_nxt_s;
  logic [BUSWIDTH-1:0] row_nxt_s;
  logic [BUSWIDTH-1:0] col_nxt_s;
  logic                last_pix_s;
  logic                moving_nxt_s;

  logic                rd_req_nxt_s;
  logic [BUSWIDTH-1:0] rd_addr_nxt_s;
  logic                rd_eol_nxt_s;
  logic                rd_eof_nxt_s;
  logic                res_ready_nxt_s;
  logic                wr_req_nxt_s;
  logic [BUSWIDTH-1:0] wr_addr_nxt_s;

  assign rd_req    = rd_req_r;
  assign rd_addr   = rd_addr_r;
  assign rd_eol    = rd_eol_r;
  assign rd_eof    = rd_eof_r;
  assign res_ready = res_ready_r;
  assign wr_req    = wr_req_r;
  assign wr_addr   = wr_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  assign edge_s     = start & ~start_q_r;
  assign load_s     = (state_r == S_LOAD);
  assign rd_fire_s  = rd_ack & rd_req_r;
  assign wr_fire_s  = wr_ack & wr_req_r;
  assign res_fire_s = res_valid & res_ready_r;
  assign bad_dim_s  = (width < MIN) | (height < MIN);

  // While in LOAD the config registers are still being written, so the
  // next-cycle output values are computed from the live inputs instead.
  assign cfg_w_s  = load_s ? width : width_r;
  assign cfg_h_s  = load_s ? height : height_r;
  assign rbase_s  = load_s ? read_start_address : rbase_r;
  assign wtotal_s = load_s ? ((width - TWO) * (height - TWO)) : wtotal_r;

  raster_counter #(
    .BUSWIDTH (BUSWIDTH)
  ) u_raster (
    .ahb_hclk (ahb_hclk),
    .n_rst    (n_rst),
    .clear    (load_s),
    .enable   (rd_fire_s),
    .width    (width_r),
    .height   (height_r),
    .row_nxt  (row_nxt_s),
    .col_nxt  (col_nxt_s),
    .last_pix (last_pix_s)
  );

  // Result counter after this edge (an ack in this cycle already counts)
  always_comb begin
    wcount_nxt_s = wcount_r;
    if (load_s) begin
      wcount_nxt_s = ZERO;
    end else if (wr_fire_s) begin
      wcount_nxt_s = wcount_r + ONE;
    end else begin
      wcount_nxt_s = wcount_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (edge_s) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LOAD: begin
        if (bad_dim_s) begin
          state_nxt_s = S_ERROR;
        end else begin
          state_nxt_s = S_READ;
        end
      end
      S_READ: begin
        if (rd_fire_s && last_pix_s) begin
          state_nxt_s = (wcount_nxt_s == wtotal_r) ? S_DONE : S_DRAIN;
        end else begin
          state_nxt_s = S_READ;
        end
      end
      S_DRAIN: begin
        if (wcount_nxt_s == wtotal_r) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state
  always_comb begin
    moving_nxt_s = is_moving(state_nxt_s);
    rd_req_nxt_s = (state_nxt_s == S_READ);

    // row*width+col of the position the counter moves to
    if (rd_req_nxt_s) begin
      rd_addr_nxt_s = rbase_s + (row_nxt_s * cfg_w_s) + col_nxt_s;
      rd_eol_nxt_s  = (col_nxt_s == (cfg_w_s - ONE));
      rd_eof_nxt_s  = (col_nxt_s == (cfg_w_s - ONE)) && (row_nxt_s == (cfg_h_s - ONE));
    end else begin
      rd_addr_nxt_s = ZERO;
      rd_eol_nxt_s  = 1'b0;
      rd_eof_nxt_s  = 1'b0;
    end

    // A result and a write ack can never coincide: res_ready is only
    // offered while no write is pending.
    if (!moving_nxt_s) begin
      wr_req_nxt_s = 1'b0;
    end else if (res_fire_s) begin
      wr_req_nxt_s = 1'b1;
    end else if (wr_fire_s) begin
      wr_req_nxt_s = 1'b0;
    end else begin
      wr_req_nxt_s = wr_req_r;
    end

    if (!wr_req_nxt_s) begin
      wr_addr_nxt_s = ZERO;
    end else if (res_fire_s) begin
      wr_addr_nxt_s = wbase_r + wcount_r;
    end else begin
      wr_addr_nxt_s = wr_addr_r;
    end

    res_ready_nxt_s = moving_nxt_s && !wr_req_nxt_s && (wcount_nxt_s < wtotal_s);
  end

  // State, edge detector and status registers
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= S_IDLE;
      // Comes out of reset as "high" so a level already high at release
      // is not mistaken for a fresh kick-off.
      start_q_r <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      start_q_r <= start;
      busy_r    <= is_busy(state_nxt_s);
      done_r    <= (state_nxt_s == S_DONE);
      err_r     <= (state_nxt_s == S_ERROR);
    end
  end

  // Latched configuration and result counter
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      width_r  <= ZERO;
      height_r <= ZERO;
      rbase_r  <= ZERO;
      wbase_r  <= ZERO;
      wtotal_r <= ZERO;
      wcount_r <= ZERO;
    end else begin
      if (load_s) begin
        width_r  <= width;
        height_r <= height;
        rbase_r  <= read_start_address;
        wbase_r  <= write_start_address;
        wtotal_r <= wtotal_s;
      end else begin
        width_r  <= width_r;
        height_r <= height_r;
        rbase_r  <= rbase_r;
        wbase_r  <= wbase_r;
        wtotal_r <= wtotal_r;
      end
      wcount_r <= wcount_nxt_s;
    end
  end

  // Bus-facing output registers
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      rd_req_r    <= 1'b0;
      rd_addr_r   <= ZERO;
      rd_eol_r    <= 1'b0;
      rd_eof_r    <= 1'b0;
      res_ready_r <= 1'b0;
      wr_req_r    <= 1'b0;
      wr_addr_r   <= ZERO;
    end else begin
      rd_req_r    <= rd_req_nxt_s;
      rd_addr_r   <= rd_addr_nxt_s;
      rd_eol_r    <= rd_eol_nxt_s;
      rd_eof_r    <= rd_eof_nxt_s;
      res_ready_r <= res_ready_nxt_s;
      wr_req_r    <= wr_req_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_pixel_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_addr_sequencer
// Scoreboard bench: the stimulus process pushes the expected read and write
// transactions of each run into queues; a monitor process on the falling
// clock edge drives the bus acks and compares every presented request
// against the head of the matching queue.
// ---------------------------------------------------------------------------
module tb_pixel_addr_sequencer;

  logic        ahb_hclk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] width;
  logic [31:0] height;
  logic [31:0] read_start_address;
  logic [31:0] write_start_address;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic        rd_eol;
  logic        rd_eof;
  logic        res_valid;
  logic        res_ready;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic        eol;
    logic        eof;
  } rd_exp_t;

  rd_exp_t     exp_rd[$];
  logic [31:0] exp_wr[$];

  int total = 0;
  int bad = 0;
  int rd_seen = 0;
  int accepted = 0;
  int rd_mode = 0;   // 0: rd_ack always 1, 1: three stall cycles per read

  pixel_addr_sequencer #(.BUSWIDTH(32)) dut (
    .ahb_hclk            (ahb_hclk),
    .n_rst               (n_rst),
    .start               (start),
    .width               (width),
    .height              (height),
    .read_start_address  (read_start_address),
    .write_start_address (write_start_address),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_ack              (rd_ack),
    .rd_eol              (rd_eol),
    .rd_eof              (rd_eof),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_ack              (wr_ack),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  initial forever #5 ahb_hclk = ~ahb_hclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ahb_hclk);
    #2;
  endtask

  task automatic cfg(input logic [31:0] w, input logic [31:0] h,
                     input logic [31:0] rb, input logic [31:0] wb);
    width = w;
    height = h;
    read_start_address = rb;
    write_start_address = wb;
  endtask

  // Expected raster reads: base + index, eol every w-th, eof on the last
  task automatic push_reads(input logic [31:0] base, input int w, input int h);
    rd_exp_t e;
    for (int i = 0; i < w * h; i++) begin
      e.addr = base + 32'(i);
      e.eol  = ((i % w) == (w - 1));
      e.eof  = (i == (w * h - 1));
      exp_rd.push_back(e);
    end
  endtask

  task automatic push_writes(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_wr.push_back(base + 32'(i));
  endtask

  task automatic kick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic wait_status(input string name, input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(done | err), 64'd1);
  endtask

  task automatic wait_reads(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (rd_seen < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(rd_seen >= target), 64'd1);
  endtask

  task automatic end_of_run(input string name, input int reads);
    check({name, "_status"}, 64'({busy, done, err}), 64'(3'b010));
    check({name, "_reads"}, 64'(rd_seen), 64'(reads));
    check({name, "_accepted"}, 64'(accepted), 64'd2);
    check({name, "_rdq_left"}, 64'(exp_rd.size()), 64'd0);
    check({name, "_wrq_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  // Monitor: drive acks for the coming rising edge, then score outputs
  initial begin
    int stall;
    logic ra;
    rd_exp_t e;
    stall = 0;
    forever begin
      @(negedge ahb_hclk);
      if (rd_mode == 0) begin
        ra = 1'b1;
      end else if (!rd_req) begin
        ra = 1'b0;
        stall = 0;
      end else if (stall == 3) begin
        ra = 1'b1;
        stall = 0;
      end else begin
        ra = 1'b0;
        stall++;
      end
      rd_ack = ra;
      wr_ack = 1'b1;

      if (rd_req) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", 64'(rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_rd[0];
          check("rd_addr_eol_eof", 64'({rd_addr, rd_eol, rd_eof}), 64'({e.addr, e.eol, e.eof}));
          if (ra) begin
            void'(exp_rd.pop_front());
            rd_seen++;
          end
        end
      end else begin
        check("rd_flags_idle", 64'({rd_eol, rd_eof}), 64'd0);
      end

      if (wr_req) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("wr_addr", 64'(wr_addr), 64'(exp_wr[0]));
          void'(exp_wr.pop_front());
        end
      end

      if (res_valid && res_ready) accepted++;
    end
  end

  // Stimulus
  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    res_valid = 1'b0;
    cfg(32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) tick();
    check("rst_flags", 64'({rd_req, wr_req, res_ready, rd_eol, rd_eof, busy, done, err}), 64'd0);
    check("rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    n_rst = 1'b1;
    tick();

    // 4x3 run, acks always high, results always offered (third is refused)
    cfg(32'd4, 32'd3, 32'h100, 32'h200);
    push_reads(32'h100, 4, 3);
    push_writes(32'h200, 2);
    rd_seen = 0;
    accepted = 0;
    res_valid = 1'b1;
    start = 1'b1;
    tick();
    check("s1_load", 64'({busy, rd_req, done}), 64'(3'b100));
    tick();
    check("s1_first_read", 64'({busy, rd_req}), 64'(2'b11));
    wait_status("s1_wait_done", 100);
    end_of_run("s1", 12);
    res_valid = 1'b0;

    // start kept high after done: no new run
    repeat (10) tick();
    check("s4_held_start", 64'({busy, done, rd_req}), 64'(3'b010));

    // toggled start: identical second run
    push_reads(32'h100, 4, 3);
    push_writes(32'h200, 2);
    rd_seen = 0;
    accepted = 0;
    res_valid = 1'b1;
    kick();
    check("s4_load", 64'({busy, done}), 64'(2'b10));
    wait_status("s4_wait_done", 100);
    end_of_run("s4", 12);
    res_valid = 1'b0;

    // too-narrow image goes to ERROR without any read
    cfg(32'd2, 32'd5, 32'h100, 32'h200);
    kick();
    check("s2_load", 64'({busy, err}), 64'(2'b10));
    tick();
    check("s2_error", 64'({busy, err, rd_req, done}), 64'(4'b0100));
    repeat (4) tick();
    check("s2_err_held", 64'({busy, err}), 64'(2'b01));
    cfg(32'd4, 32'd3, 32'h100, 32'h200);
    push_reads(32'h100, 4, 3);
    push_writes(32'h200, 2);
    rd_seen = 0;
    accepted = 0;
    res_valid = 1'b1;
    kick();
    check("s2_err_cleared", 64'({busy, err}), 64'(2'b10));
    wait_status("s2_wait_done", 100);
    end_of_run("s2", 12);
    res_valid = 1'b0;

    // stalled reads, wrapping addresses, results only after reads: DRAIN
    rd_mode = 1;
    cfg(32'd4, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    push_reads(32'hFFFF_FFFC, 4, 3);
    push_writes(32'hFFFF_FFFF, 2);
    rd_seen = 0;
    accepted = 0;
    kick();
    wait_reads("s3_wait_reads", 12, 200);
    tick();
    check("s3_drain", 64'({busy, done, rd_req, res_ready}), 64'(4'b1001));
    res_valid = 1'b1;
    wait_status("s3_wait_done", 100);
    end_of_run("s3", 12);
    res_valid = 1'b0;

    // reset in the middle of READ
    cfg(32'd4, 32'd3, 32'h100, 32'h200);
    push_reads(32'h100, 4, 3);
    push_writes(32'h200, 2);
    rd_seen = 0;
    res_valid = 1'b1;
    kick();
    wait_reads("s5_wait_reads", 2, 100);
    n_rst = 1'b0;
    #1;
    check("s5_rst_flags", 64'({rd_req, wr_req, res_ready, rd_eol, rd_eof, busy, done, err}), 64'd0);
    check("s5_rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    exp_rd.delete();
    exp_wr.delete();
    tick();
    tick();
    n_rst = 1'b1;
    repeat (8) tick();
    check("s5_idle_after_rst", 64'({busy, done, err, rd_req}), 64'd0);
    rd_mode = 0;
    push_reads(32'h100, 4, 3);
    push_writes(32'h200, 2);
    rd_seen = 0;
    accepted = 0;
    kick();
    check("s5_restart", 64'(busy), 64'd1);
    wait_status("s5_wait_done", 100);
    end_of_run("s5", 12);
    res_valid = 1'b0;

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_addr_sequencer.md
PIXEL_ADDR_SEQUENCER -- requirements
Module: pixel_addr_sequencer

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32, the width of the address and config bus.
REQ-002 SHALL have port ahb_hclk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: the kick-off level from the configuration initializer; only its rising edge triggers a run.
REQ-005 SHALL have ports width and height, input, BUSWIDTH bits each: image dimensions in pixels.
REQ-006 SHALL have ports read_start_address and write_start_address, input, BUSWIDTH bits each: base addresses of the source and result images.
REQ-007 SHALL have ports rd_req (output, 1), rd_addr (output, BUSWIDTH) and rd_ack (input, 1): the pixel-read request to the bus master.
REQ-008 SHALL have ports rd_eol and rd_eof, output, 1 bit each: the current read is the last pixel of its row, and the last pixel of the image, respectively.
REQ-009 SHALL have ports res_valid (input, 1) and res_ready (output, 1): the result handshake from the filter pipeline.
REQ-010 SHALL have ports wr_req (output, 1), wr_addr (output, BUSWIDTH) and wr_ack (input, 1): the result-write request to the bus master.
REQ-011 SHALL have ports busy, done and err, output, 1 bit each: status.

Function
REQ-012 SHALL implement the states IDLE, LOAD, READ, DRAIN, DONE and ERROR.
REQ-013 SHALL detect a rising edge of start using a registered copy of start; a start level held high SHALL NOT retrigger a run.
REQ-014 SHALL move from IDLE, DONE or ERROR to LOAD in the cycle after a rising edge of start; start edges in LOAD, READ or DRAIN SHALL be ignored.
REQ-015 In LOAD, SHALL latch all four config inputs and clear every counter; next state SHALL be ERROR if width<3 or height<3, otherwise READ.
REQ-016 In READ, SHALL drive rd_req=1 and rd_addr = read_start_address + row*width + col, one address per pixel.
REQ-017 SHALL hold rd_req and rd_addr stable until rd_ack=1; on each rd_ack SHALL advance col, wrapping col to 0 and incrementing row when col==width-1.
REQ-018 SHALL assert rd_eol when col==width-1, and rd_eof when additionally row==height-1, both qualified by rd_req.
REQ-019 SHALL leave READ on rd_ack of the last pixel; next state SHALL be DONE if all writes are complete, otherwise DRAIN.
REQ-020 The write side SHALL run independently of and concurrently with the read side while in READ or DRAIN.
REQ-021 SHALL drive res_ready=1 only when no write is pending and wcount < (width-2)*(height-2).
REQ-022 On res_valid & res_ready, SHALL assert wr_req with wr_addr = write_start_address + wcount on the next cycle, and hold both until wr_ack.
REQ-023 On wr_ack, SHALL drop wr_req and increment wcount.
REQ-024 SHALL ignore res_valid beyond the expected result count (res_ready stays 0) without raising err.
REQ-025 SHALL move from DRAIN to DONE on the final wr_ack.
REQ-026 SHALL drive busy=1 in LOAD, READ and DRAIN.
REQ-027 SHALL drive done=1 in DONE and err=1 in ERROR, each held until the next rising edge of start.
REQ-028 SHALL accept rd_ack and wr_ack in the same cycle, both taking effect.
REQ-029 SHALL ignore rd_ack when rd_req=0 and wr_ack when wr_req=0.
REQ-030 SHALL compute addresses modulo 2^BUSWIDTH (wrap-around) without flagging an error.

Reset
REQ-031 While n_rst=0, SHALL force state=IDLE and clear all counters and latched config.
REQ-032 While n_rst=0, SHALL drive rd_req, wr_req, res_ready, rd_eol, rd_eof, busy, done and err to 0, and rd_addr and wr_addr to 0.
REQ-033 A reset mid-run SHALL abandon the run; after reset release, a new rising edge of start SHALL be required.

Structure
REQ-034 SHALL place the state enum (seq_state_t) and the constant MIN_DIM=3 in the shared package edge_pkg.
REQ-035 SHALL instantiate one sub-module, raster_counter, for the row/col counter with wrap, clear and enable.

Verification
REQ-036 Scenario 1: width=4, height=3, read base 0x100, write base 0x200, rd_ack always 1 -> reads 0x100..0x10B; rd_eol at 0x103/0x107/0x10B; rd_eof at 0x10B; two results write 0x200 and 0x201; then done=1.
REQ-037 Scenario 2: width=2, height=5 -> ERROR one cycle after LOAD; err=1, no rd_req; next start edge with valid config clears err.
REQ-038 Scenario 3: rd_ack held low 3 cycles per request -> rd_addr stable during stall; 12 reads total, in order.
REQ-039 Scenario 4: start held high after done -> no new run; start toggled low then high -> second run with identical address sequence.
REQ-040 Scenario 5: n_rst pulsed low in the middle of READ -> all outputs 0 immediately, IDLE; no activity until the next start edge.
REQ-041 Scenario 6: third res_valid in the 4x3 case and simultaneous rd_ack/wr_ack -> res_ready=0 for the extra result; both acks counted.
